rsa_control: RTL and testbench
==============================

Name: rsa_control

Overview:
- RSA datapath controller. Derives key material from primes p, q, then computes msg_out = msg_in^k mod n by square-and-multiply.
- k = e (fixed public exponent 65537) when encrypting, k = d = e^-1 mod phi when decrypting.
- Sits between the host registers (p, q, message, mode) and the crypto result bus.
- Fully sequential: bit-serial multiplier, divider and modular multiplier. No wide combinational multiplier.

Parameters:
- WIDTH, 128: prime width. All data ports are 2*WIDTH bits. p and q must each be < 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high. Clears state and continuously loads p/q; key generation starts on deassertion.
- reset1  in  1  synchronous active-high start strobe, sampled on clk.
- encrypt_decrypt  in  1  1 = encrypt (exponent e), 0 = decrypt (exponent d). Sampled at start.
- p  in  2*WIDTH  prime p (upper WIDTH bits zero).
- q  in  2*WIDTH  prime q (upper WIDTH bits zero).
- msg_in  in  2*WIDTH  message, required < n. Sampled at start.
- msg_out  out  2*WIDTH  result; holds until the next start or reset.
- mod_exp_finish  out  1  level done flag.

Behaviour:
- Reset (async, high):
  - msg_out = 0, mod_exp_finish = 0.
  - FSM forced to KEYGEN_N; pending-start flag cleared.
  - p and q registered every cycle while reset is high.
- Key generation (runs once after each reset deassertion):
  - KEYGEN_N: n = p*q, shift-add, one multiplier bit per cycle, 2*WIDTH cycles.
  - KEYGEN_PHI: phi = (p-1)*(q-1), same multiplier.
  - KEYGEN_INV: d = 65537^-1 mod phi by iterative extended Euclid.
    - Each quotient comes from a restoring bit-serial divider (1 bit/cycle).
    - Coefficient result normalised into [0, phi).
    - If gcd(65537, phi) != 1, d = 0.
  - Then go to IDLE.
- Start:
  - A cycle with reset1 = 1 latches msg_in and encrypt_decrypt, clears mod_exp_finish and sets the pending flag.
  - If reset1 arrives during key generation, it stays pending and the exponentiation launches the cycle after KEYGEN_INV completes.
  - reset1 during an exponentiation aborts it and restarts with the newly latched inputs.
- Exponentiation:
  - acc = 1. Scan all 2*WIDTH exponent bits MSB-first.
  - For each bit: EXP_SQ does acc = acc*acc mod n. If the bit is 1, EXP_MUL does acc = acc*m mod n.
  - Modular multiply is interleaved shift-add over 2*WIDTH bits, one bit per cycle.
    - Per bit: R = 2R + b*a, then conditionally subtract n up to twice.
    - Internal R is 2*WIDTH+2 bits wide.
  - Latency is at most 2*WIDTH*(2*(2*WIDTH)+4) cycles after launch.
- Completion:
  - In DONE: msg_out = acc and mod_exp_finish = 1.
  - Both hold until the next reset1 or reset. Return to IDLE.
- Boundaries:
  - msg_in = 0 gives 0.
  - msg_in = 1 gives 1.
  - exponent 0 (d = 0 case) gives 1.
  - msg_in >= n is unsupported: result is unspecified, but mod_exp_finish still asserts.
- Input stability:
  - p and q changing outside reset have no effect.
  - msg_in and encrypt_decrypt changing after the start cycle have no effect.
- Reset mid-operation: immediate abort, outputs cleared, keys recomputed after deassertion.

Test Plan:
- Encrypt, small key: WIDTH=128, p=61, q=53 (n=3233, phi=3120, e effective 17), encrypt_decrypt=1, msg_in=65. Pulse reset, then reset1 after keygen. Expect msg_out=2790 and mod_exp_finish=1.
- Decrypt, same key: encrypt_decrypt=0, msg_in=2790, reset1 pulse. Expect msg_out=65 (d=2753).
- Early start: same as the encrypt case but reset1 pulsed 10 cycles after reset deasserts, during keygen. Expect the start is held pending, then msg_out=2790 and mod_exp_finish=1.
- Full-width round trip: p=113680897410347, q=7999808077935876437321, msg_in=0x262d806a3e18f03ab37b2857e7e149, encrypt. Expect finish with msg_out = msg_in^65537 mod n. Feeding that back with encrypt_decrypt=0 returns 0x262d806a3e18f03ab37b2857e7e149.
- Reset mid-exponentiation: assert reset mid-run. Expect msg_out=0 and mod_exp_finish=0 immediately; after deassertion plus reset1, the correct result is produced.
- Edge messages: msg_in=0 gives 0, msg_in=1 gives 1, in both modes. mod_exp_finish stays low until reset1 is pulsed again.

Source files
------------

// File: rtl/rsa_control.sv
// RSA controller: derives n, phi and d from p, q, then runs
// square-and-multiply modular exponentiation, all bit-serial.
module rsa_control #(
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reset1,
  input  logic               encrypt_decrypt,
  input  logic [2*WIDTH-1:0] p,
  input  logic [2*WIDTH-1:0] q,
  input  logic [2*WIDTH-1:0] msg_in,
  output logic [2*WIDTH-1:0] msg_out,
  output logic               mod_exp_finish
);
  localparam int W2 = 2*WIDTH;
  localparam int CW = $clog2(W2);
  localparam logic [CW-1:0] LAST = CW'(W2-1);
  localparam logic [W2-1:0] E   = W2'(65537);
  localparam logic [W2-1:0] ONE = W2'(1);

  localparam logic [3:0] KEYGEN_N   = 4'd0;
  localparam logic [3:0] KEYGEN_PHI = 4'd1;
  localparam logic [3:0] KEYGEN_INV = 4'd2;
  localparam logic [3:0] INV_DIV    = 4'd3;
  localparam logic [3:0] INV_MUL    = 4'd4;
  localparam logic [3:0] IDLE       = 4'd5;
  localparam logic [3:0] EXP_SQ     = 4'd6;
  localparam logic [3:0] EXP_MUL    = 4'd7;
  localparam logic [3:0] DONE       = 4'd8;

  logic [3:0]    state;
  logic          ld;
  logic          pending;
  logic          mode_r;
  logic [W2-1:0] m_r;
  logic [W2-1:0] p_r;
  logic [W2-1:0] q_r;
  logic [W2-1:0] n_r;
  logic [W2-1:0] phi_r;
  logic [W2-1:0] d_r;
  logic [CW-1:0] cnt;
  logic [W2:0]   mul_a;
  logic [W2-1:0] mul_b;
  logic [W2:0]   mul_acc;
  logic [W2-1:0] r0;
  logic [W2-1:0] r1;
  logic [W2:0]   t0;
  logic [W2:0]   t1;
  logic [W2-1:0] dv_q;
  logic [W2-1:0] dv_rem;
  logic [W2-1:0] exp_r;
  logic [CW-1:0] bit_cnt;
  logic [W2-1:0] acc;
  logic [W2-1:0] mm_a;
  logic [W2-1:0] mm_b;
  logic [W2-1:0] mm_r;

  logic [W2:0]   mul_nx;
  logic [W2:0]   rem_sh;
  logic [W2-1:0] rem_nx;
  logic [W2-1:0] quo_nx;
  logic [W2+1:0] n_ext;
  logic [W2+1:0] mm_sum;
  logic [W2+1:0] mm_s1;
  logic [W2-1:0] mm_nx;
  logic [W2-1:0] d_fix;

  always_comb begin
    mul_nx = mul_acc + (mul_b[0] ? mul_a : '0);
    rem_sh = {dv_rem, dv_q[W2-1]};
    quo_nx = {dv_q[W2-2:0], 1'b0};
    rem_nx = rem_sh[W2-1:0];
    if (rem_sh >= {1'b0, r1}) begin
      rem_nx    = rem_sh[W2-1:0] - r1;
      quo_nx[0] = 1'b1;
    end
    n_ext  = {2'b00, n_r};
    mm_sum = {1'b0, mm_r, 1'b0} + (mm_b[W2-1] ? {2'b00, mm_a} : '0);
    mm_s1  = (mm_sum >= n_ext) ? mm_sum - n_ext : mm_sum;
    mm_nx  = (mm_s1 >= n_ext) ? mm_s1[W2-1:0] - n_r : mm_s1[W2-1:0];
    d_fix  = t0[W2] ? t0[W2-1:0] + phi_r : t0[W2-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_r <= p;
      q_r <= q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= KEYGEN_N;
      ld             <= 1'b1;
      pending        <= 1'b0;
      mode_r         <= 1'b0;
      m_r            <= '0;
      n_r            <= '0;
      phi_r          <= '0;
      d_r            <= '0;
      cnt            <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_acc        <= '0;
      r0             <= '0;
      r1             <= '0;
      t0             <= '0;
      t1             <= '0;
      dv_q           <= '0;
      dv_rem         <= '0;
      exp_r          <= '0;
      bit_cnt        <= '0;
      acc            <= '0;
      mm_a           <= '0;
      mm_b           <= '0;
      mm_r           <= '0;
      msg_out        <= '0;
      mod_exp_finish <= 1'b0;
    end else begin
      unique case (state)
        KEYGEN_N, KEYGEN_PHI: begin
          if (ld) begin
            ld      <= 1'b0;
            cnt     <= '0;
            mul_acc <= '0;
            mul_a   <= (state == KEYGEN_N) ?
                       {1'b0, p_r} : {1'b0, p_r - ONE};
            mul_b   <= (state == KEYGEN_N) ? q_r : q_r - ONE;
          end else begin
            mul_acc <= mul_nx;
            mul_a   <= {mul_a[W2-1:0], 1'b0};
            mul_b   <= {1'b0, mul_b[W2-1:1]};
            cnt     <= cnt + CW'(1);
            if (cnt == LAST) begin
              ld <= 1'b1;
              if (state == KEYGEN_N) begin
                n_r   <= mul_nx[W2-1:0];
                state <= KEYGEN_PHI;
              end else begin
                phi_r <= mul_nx[W2-1:0];
                r0    <= mul_nx[W2-1:0];
                r1    <= E;
                t0    <= '0;
                t1    <= {{W2{1'b0}}, 1'b1};
                state <= KEYGEN_INV;
              end
            end
          end
        end
        KEYGEN_INV: begin
          if (r1 == '0) begin
            // gcd(e, phi) != 1 leaves no inverse; d = 0
            d_r   <= (r0 == ONE) ? d_fix : '0;
            state <= IDLE;
          end else begin
            ld    <= 1'b1;
            state <= INV_DIV;
          end
        end
        INV_DIV: begin
          if (ld) begin
            ld     <= 1'b0;
            cnt    <= '0;
            dv_q   <= r0;
            dv_rem <= '0;
          end else begin
            dv_q   <= quo_nx;
            dv_rem <= rem_nx;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              r0    <= r1;
              r1    <= rem_nx;
              ld    <= 1'b1;
              state <= INV_MUL;
            end
          end
        end
        INV_MUL: begin
          // two's complement product is exact mod 2^(W2+1)
          if (ld) begin
            ld      <= 1'b0;
            cnt     <= '0;
            mul_acc <= '0;
            mul_a   <= t1;
            mul_b   <= dv_q;
          end else begin
            mul_acc <= mul_nx;
            mul_a   <= {mul_a[W2-1:0], 1'b0};
            mul_b   <= {1'b0, mul_b[W2-1:1]};
            cnt     <= cnt + CW'(1);
            if (cnt == LAST) begin
              t0    <= t1;
              t1    <= t0 - mul_nx;
              state <= KEYGEN_INV;
            end
          end
        end
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            acc     <= ONE;
            exp_r   <= mode_r ? E : d_r;
            bit_cnt <= LAST;
            ld      <= 1'b1;
            state   <= EXP_SQ;
          end
        end
        EXP_SQ, EXP_MUL: begin
          if (ld) begin
            ld   <= 1'b0;
            cnt  <= '0;
            mm_r <= '0;
            mm_a <= (state == EXP_SQ) ? acc : m_r;
            mm_b <= acc;
          end else begin
            mm_r <= mm_nx;
            mm_b <= {mm_b[W2-2:0], 1'b0};
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
              acc <= mm_nx;
              ld  <= 1'b1;
              if (state == EXP_SQ && exp_r[W2-1]) begin
                state <= EXP_MUL;
              end else begin
                exp_r <= {exp_r[W2-2:0], 1'b0};
                if (bit_cnt == '0) begin
                  state <= DONE;
                end else begin
                  bit_cnt <= bit_cnt - CW'(1);
                  state   <= EXP_SQ;
                end
              end
            end
          end
        end
        DONE: begin
          msg_out        <= acc;
          mod_exp_finish <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // a start during keygen waits; otherwise it aborts and relaunches
      if (reset1) begin
        m_r            <= msg_in;
        mode_r         <= encrypt_decrypt;
        mod_exp_finish <= 1'b0;
        pending        <= 1'b1;
        if (state >= IDLE) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rsa_control.sv
// Randomized self-checking bench for rsa_control against an
// arithmetic RSA model (modular inverse and modular power).
module tb_rsa_control;
  localparam int WIDTH  = 16;
  localparam int W2     = 2*WIDTH;
  localparam int BUDGET = 9000;
  localparam longint unsigned E = 65537;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reset1 = 1'b0;
  logic          encrypt_decrypt = 1'b0;
  logic [W2-1:0] p = '0;
  logic [W2-1:0] q = '0;
  logic [W2-1:0] msg_in = '0;
  logic [W2-1:0] msg_out;
  logic          mod_exp_finish;

  int checks = 0;
  int errors = 0;
  longint unsigned kn, kphi, kd;

  rsa_control #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .reset1(reset1),
    .encrypt_decrypt(encrypt_decrypt),
    .p(p),
    .q(q),
    .msg_in(msg_in),
    .msg_out(msg_out),
    .mod_exp_finish(mod_exp_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned mod_pow(
      input longint unsigned b, input longint unsigned k,
      input longint unsigned n);
    longint unsigned r = 1 % n;
    longint unsigned x = b % n;
    while (k != 0) begin
      if (k[0]) r = (r * x) % n;
      x = (x * x) % n;
      k = k >> 1;
    end
    return r;
  endfunction

  function automatic longint unsigned mod_inv(
      input longint unsigned e, input longint unsigned m);
    longint a = longint'(m);
    longint b = longint'(e);
    longint x0 = 0;
    longint x1 = 1;
    longint qq, t;
    while (b != 0) begin
      qq = a / b;
      t = a - qq * b; a = b; b = t;
      t = x0 - qq * x1; x0 = x1; x1 = t;
    end
    if (a != 1) return 0;
    x0 = x0 % longint'(m);
    if (x0 < 0) x0 = x0 + longint'(m);
    return longint'(x0);
  endfunction

  function automatic bit is_prime(input longint unsigned x);
    if (x < 2) return 1'b0;
    for (longint unsigned f = 2; f * f <= x; f++)
      if (x % f == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint unsigned rand_prime();
    longint unsigned x;
    do x = longint'($urandom_range(65535, 257)) | 1;
    while (!is_prime(x));
    return x;
  endfunction

  task automatic do_reset(input longint unsigned pp,
                          input longint unsigned qq);
    @(negedge clk);
    reset = 1'b1;
    p = pp[W2-1:0];
    q = qq[W2-1:0];
    repeat (3) @(negedge clk);
    chk("rst_msg_out", msg_out, 0);
    chk("rst_finish", mod_exp_finish, 0);
    reset = 1'b0;
    kn   = pp * qq;
    kphi = (pp - 1) * (qq - 1);
    kd   = mod_inv(E, kphi);
    p = $urandom;
    q = $urandom;
  endtask

  task automatic start(input longint unsigned m, input logic mode);
    @(negedge clk);
    msg_in = m[W2-1:0];
    encrypt_decrypt = mode;
    reset1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0;
    msg_in = $urandom;
    encrypt_decrypt = 1'($urandom);
    chk("start_clears_finish", mod_exp_finish, 0);
  endtask

  task automatic wait_done(input string tag, input longint unsigned exp);
    int n = 0;
    while (mod_exp_finish !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finish"}, mod_exp_finish, 1);
    chk(tag, msg_out, exp);
  endtask

  task automatic run(input string tag, input longint unsigned m,
                     input logic mode, input longint unsigned exp);
    start(m, mode);
    wait_done(tag, exp);
  endtask

  task automatic run_model(input string tag, input longint unsigned m,
                           input logic mode, output longint unsigned r);
    r = mod_pow(m, mode ? E : kd, kn);
    run(tag, m, mode, r);
  endtask

  initial begin
    longint unsigned m, c, r, pp, qq;

    do_reset(61, 53);
    repeat (1000) @(negedge clk);
    chk("idle_no_finish", mod_exp_finish, 0);
    run("enc_65", 65, 1'b1, 2790);
    run("dec_2790", 2790, 1'b0, 65);
    run("enc_0", 0, 1'b1, 0);
    run("enc_1", 1, 1'b1, 1);
    run("dec_0", 0, 1'b0, 0);
    run("dec_1", 1, 1'b0, 1);
    repeat (20) @(negedge clk);
    chk("hold_finish", mod_exp_finish, 1);
    chk("hold_msg_out", msg_out, 1);

    do_reset(61, 53);
    repeat (10) @(negedge clk);
    run("early_start", 65, 1'b1, 2790);

    start(1234, 1'b1);
    repeat (200) @(negedge clk);
    run("restart_abort", 65, 1'b1, 2790);

    start(65, 1'b1);
    repeat (500) @(negedge clk);
    reset = 1'b1;
    p = 61;
    q = 53;
    #1;
    chk("midrun_rst_msg_out", msg_out, 0);
    chk("midrun_rst_finish", mod_exp_finish, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    p = $urandom;
    q = $urandom;
    run("after_rst_dec", 2790, 1'b0, 65);

    do_reset(65521, 65519);
    m = longint'($urandom) % kn;
    run_model("full_enc", m, 1'b1, c);
    run_model("full_dec", c, 1'b0, r);
    chk("full_roundtrip", msg_out, m);

    for (int i = 0; i < 5; i++) begin
      pp = rand_prime();
      do qq = rand_prime(); while (qq == pp);
      do_reset(pp, qq);
      m = longint'($urandom) % kn;
      if ($urandom_range(1, 0) == 1) begin
        run_model("rnd_enc", m, 1'b1, c);
        run_model("rnd_dec", c, 1'b0, r);
      end else begin
        run_model("rnd_dec", m, 1'b0, c);
        run_model("rnd_enc", c, 1'b1, r);
      end
      chk("rnd_roundtrip", msg_out, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
